// File: rtl/echo_range_bcd.sv
// Ultrasonic ranger: periodic trigger, echo width in cm, sequential BCD.
// Option macro ECHO_HOLD_ON_TIMEOUT_EN keeps the digits on timeout.
module echo_range_bcd #(
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3_000_000,
    parameter int CM_CYCLES      = 2900,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic       sys_clk50m,
    input  logic       sys_rst,
    input  logic       echo_in,
    output logic       trig_out,
    output logic [3:0] A0,
    output logic [3:0] A1,
    output logic [3:0] A2,
    output logic [3:0] A3,
    output logic       data_valid,
    output logic       err
);

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;

    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [PW-1:0] TRIG_AT  = PW'(TRIG_CYCLES);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(CM_CYCLES - 1);
    localparam logic [13:0]   CM_MAX   = 14'd9999;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RISE,
        S_MEASURE,
        S_CONVERT,
        S_TIMEOUT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] per_q;
    logic          trig_q;
    logic          echo_m_q, echo_s_q, echo_d_q;
    logic [TW-1:0] to_q, to_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [13:0]   cm_q, cm_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [3:0]    step_q, step_d;
    logic [15:0]   a_q, a_d;
    logic          err_q, err_d;
    logic          dv_q, dv_d;

    logic          rise, fall, to_hit;
    logic [29:0]   shifted;

    assign rise   = echo_s_q & ~echo_d_q;
    assign fall   = ~echo_s_q & echo_d_q;
    assign to_hit = (to_q == TO_LAST);

    // One double-dabble iteration: correct nibbles >= 5, then shift left.
    function automatic logic [29:0] dd_step(input logic [15:0] bcd,
                                            input logic [13:0] bin);
        logic [15:0] adj;
        adj = '0;
        for (int n = 0; n < 4; n++) begin
            if (bcd[4*n +: 4] >= 4'd5)
                adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
            else
                adj[4*n +: 4] = bcd[4*n +: 4];
        end
        return {adj[14:0], bin, 1'b0};
    endfunction

    assign shifted = dd_step(bcd_q, bin_q);

    // Free-running period counter and registered trigger pulse.
    always_ff @(posedge sys_clk50m) begin
        if (sys_rst) begin
            per_q  <= '0;
            trig_q <= 1'b0;
        end else begin
            per_q  <= (per_q == PER_LAST) ? '0 : per_q + PW'(1);
            trig_q <= (per_q < TRIG_AT);
        end
    end

    // Two-flop echo synchroniser plus edge-history flop.
    always_ff @(posedge sys_clk50m) begin
        if (sys_rst) begin
            echo_m_q <= 1'b0;
            echo_s_q <= 1'b0;
            echo_d_q <= 1'b0;
        end else begin
            echo_m_q <= echo_in;
            echo_s_q <= echo_m_q;
            echo_d_q <= echo_s_q;
        end
    end

    // Measurement FSM next-state; outputs are loaded on the edge into DONE
    // so the digits and the valid pulse appear together in the DONE cycle.
    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        a_d     = a_q;
        err_d   = err_q;
        dv_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (per_q == TRIG_AT) begin
                    state_d = S_WAIT_RISE;
                    to_d    = '0;
                end
            end
            S_WAIT_RISE: begin
                if (to_hit) begin
                    state_d = S_TIMEOUT;
                end else begin
                    to_d = to_q + TW'(1);
                    if (rise) begin
                        sub_d   = '0;
                        cm_d    = '0;
                        state_d = S_MEASURE;
                    end
                end
            end
            S_MEASURE: begin
                if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    if (cm_q != CM_MAX)
                        cm_d = cm_q + 14'd1;
                end else begin
                    sub_d = sub_q + SW'(1);
                end
                if (to_hit) begin
                    state_d = S_TIMEOUT;
                end else begin
                    to_d = to_q + TW'(1);
                    if (fall) begin
                        bin_d   = cm_d;
                        bcd_d   = '0;
                        step_d  = '0;
                        state_d = S_CONVERT;
                    end
                end
            end
            S_CONVERT: begin
                bcd_d  = shifted[29:14];
                bin_d  = shifted[13:0];
                step_d = step_q + 4'd1;
                if (step_q == 4'd13) begin
                    state_d = S_DONE;
                    a_d     = shifted[29:14];
                    err_d   = 1'b0;
                    dv_d    = 1'b1;
                end
            end
            S_TIMEOUT: begin
                state_d = S_DONE;
                err_d   = 1'b1;
                dv_d    = 1'b1;
`ifdef ECHO_HOLD_ON_TIMEOUT_EN
                a_d     = a_q;
`else
                a_d     = 16'h9999;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge sys_clk50m) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            to_q    <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            a_q     <= '0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
            a_q     <= a_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
        end
    end

    assign trig_out   = trig_q;
    assign A0         = a_q[3:0];
    assign A1         = a_q[7:4];
    assign A2         = a_q[11:8];
    assign A3         = a_q[15:12];
    assign data_valid = dv_q;
    assign err        = err_q;

endmodule
